// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4:1 mux scanner.
//   scan_state_t : scanner FSM states
//   NUM_CH       : channels behind the external mux
//   IDX_W        : width of the channel index / select bus
//   CNT_W        : width of the settle (dwell) counter
//   is_xz()      : true when a sampled level is neither a clean 0 nor 1
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    function automatic logic is_xz(input logic v);
        return (v !== 1'b0) && (v !== 1'b1);
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Settle counter for the mux scanner.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force count to zero (has priority over enable)
//   enable     : count one settle cycle
//   tc         : high during the last settle cycle (count == DWELL-1)
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (enable) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tc = enable && (cnt_reg == CNT_W'(DWELL - 1));

endmodule

// File: rtl/mux_4x1_scanner.sv
// Scans the four channels of an external 4:1 tristate mux, letting each
// channel settle for DWELL cycles before sampling the fed-back mux output.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin one scan (ignored while busy)
//   cont        : continuous mode, only looked at when a snapshot is accepted
//   s1, s0      : mux select lines, {s1,s0} = channel index
//   o0          : mux output fed back for sampling
//   snap        : captured levels, bit n = channel n
//   snap_xz     : bit n set when channel n sampled as x or z
//   snap_valid  : snapshot available (DONE state)
//   snap_ready  : consumer accepts the snapshot
//   busy        : any state other than IDLE
module mux_4x1_scanner
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    output logic              s1,
    output logic              s0,
    input  logic              o0,
    output logic [NUM_CH-1:0] snap,
    output logic [NUM_CH-1:0] snap_xz,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic              busy
);

    scan_state_t       state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [NUM_CH-1:0] shadow_reg, shadow_xz_reg;
    logic [NUM_CH-1:0] cap_lvl, cap_xz;
    logic [NUM_CH-1:0] snap_reg, snap_xz_reg;
    logic              load_snap;
    logic              dwell_tc;
    logic              sample_lvl;
    logic              sample_xz;

    // Counter is held clear outside SETTLE, so every SETTLE entry starts at 0.
    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_reg != SETTLE),
        .enable (state_reg == SETTLE),
        .tc     (dwell_tc)
    );

    assign sample_lvl = (o0 === 1'b1);
    assign sample_xz  = is_xz(o0);

    // Per-channel capture view: the channel being sampled this cycle takes the
    // live level, the others keep their shadow. The snapshot loads from this
    // view so the last channel lands in the same edge that enters DONE.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cap
        logic hit;
        assign hit         = (state_reg == SAMPLE) && (idx_reg == IDX_W'(gi));
        assign cap_lvl[gi] = hit ? sample_lvl : shadow_reg[gi];
        assign cap_xz[gi]  = hit ? sample_xz  : shadow_xz_reg[gi];
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load_snap  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SETTLE;
                    idx_next   = '0;
                end
            end
            SETTLE: begin
                if (dwell_tc) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (idx_reg == IDX_W'(NUM_CH - 1)) begin
                    state_next = DONE;
                    load_snap  = 1'b1;
                end else begin
                    // Select changes together with SETTLE entry only.
                    state_next = SETTLE;
                    idx_next   = idx_reg + IDX_W'(1);
                end
            end
            DONE: begin
                if (snap_ready) begin
                    state_next = cont ? SETTLE : IDLE;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            shadow_reg    <= '0;
            shadow_xz_reg <= '0;
            snap_reg      <= '0;
            snap_xz_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            shadow_reg    <= cap_lvl;
            shadow_xz_reg <= cap_xz;
            if (load_snap) begin
                snap_reg    <= cap_lvl;
                snap_xz_reg <= cap_xz;
            end
        end
    end

    assign s1         = idx_reg[1];
    assign s0         = idx_reg[0];
    assign snap       = snap_reg;
    assign snap_xz    = snap_xz_reg;
    assign snap_valid = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mux_4x1_scanner.sv
module tb_mux_4x1_scanner;

    localparam int DWELL    = 2;
    localparam int PER_CH   = DWELL + 1;
    localparam int SCAN_CYC = 4 * PER_CH;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       s1;
    logic       s0;
    logic       o0;
    logic [3:0] snap;
    logic [3:0] snap_xz;
    logic       snap_valid;
    logic       snap_ready;
    logic       busy;

    // Behavioural external 4:1 mux: channel values selected by {s1,s0}.
    logic [3:0] ch_val;
    logic       hiz_bit;
    assign o0 = ch_val[{s1, s0}];

    always #5 clk = ~clk;

    mux_4x1_scanner #(
        .DWELL (DWELL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .s1         (s1),
        .s0         (s0),
        .o0         (o0),
        .snap       (snap),
        .snap_xz    (snap_xz),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] last_snap;
    logic [3:0] last_xz;

    typedef struct {
        logic [3:0] val;
        logic [3:0] zmask;
        logic [3:0] exp_snap;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference rules: a channel reads 1 only when it is a clean 1, and is
    // flagged when it is neither a clean 0 nor a clean 1.
    function automatic logic [3:0] model_lvl(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (v[i] === 1'b1);
        return r;
    endfunction

    function automatic logic [3:0] model_xz(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (v[i] !== 1'b0) && (v[i] !== 1'b1);
        return r;
    endfunction

    task automatic set_channels(input logic [3:0] val, input logic [3:0] zmask);
        for (int i = 0; i < 4; i++) ch_val[i] = zmask[i] ? hiz_bit : val[i];
    endtask

    // Called at the negedge where the scan-starting edge is next. Checks the
    // select trace (channel k/PER_CH during cycle k), that the old snapshot
    // is retained, and that snap_valid rises after exactly SCAN_CYC edges.
    task automatic check_scan(input logic [3:0] exp_s, input logic [3:0] exp_x,
                              input logic [3:0] prev_s, input logic [3:0] prev_x,
                              input bit noise, input bit drop_cont);
        for (int k = 0; k < SCAN_CYC; k++) begin
            @(negedge clk);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (drop_cont && k == 5) cont = 1'b0;
            chk("sel", 32'({s1, s0}), 32'(k / PER_CH));
            chk("valid_low", 32'(snap_valid), 32'd0);
            chk("busy", 32'(busy), 32'd1);
            chk("snap_hold", 32'({snap, snap_xz}), 32'({prev_s, prev_x}));
        end
        @(negedge clk);
        start = 1'b0;
        $display("scan: snap=%b snap_xz=%b valid=%b (expect %b %b)", snap, snap_xz, snap_valid, exp_s, exp_x);
        chk("valid_rise", 32'(snap_valid), 32'd1);
        chk("snap", 32'(snap), 32'(exp_s));
        chk("snap_xz", 32'(snap_xz), 32'(exp_x));
        chk("busy_done", 32'(busy), 32'd1);
    endtask

    task automatic check_idle(input logic [3:0] exp_s, input logic [3:0] exp_x);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(snap_valid), 32'd0);
        chk("idle_sel", 32'({s1, s0}), 32'd0);
        chk("idle_snap", 32'({snap, snap_xz}), 32'({exp_s, exp_x}));
    endtask

    initial begin
        vec_t vecs[7];
        logic [3:0] ex;
        logic [3:0] es;

        hiz_bit    = 1'bz;
        rst_n      = 1'b0;
        start      = 1'b0;
        cont       = 1'b0;
        snap_ready = 1'b0;
        ch_val     = 4'b0000;
        last_snap  = 4'b0000;
        last_xz    = 4'b0000;

        vecs[0] = '{val: 4'b1010, zmask: 4'b0000, exp_snap: 4'b1010};
        vecs[1] = '{val: 4'b1010, zmask: 4'b0100, exp_snap: 4'b1010};
        vecs[2] = '{val: 4'b1111, zmask: 4'b0100, exp_snap: 4'b1011};
        vecs[3] = '{val: 4'b0000, zmask: 4'b0000, exp_snap: 4'b0000};
        vecs[4] = '{val: 4'b1111, zmask: 4'b0000, exp_snap: 4'b1111};
        vecs[5] = '{val: 4'b0110, zmask: 4'b0000, exp_snap: 4'b0110};
        vecs[6] = '{val: 4'b0101, zmask: 4'b1001, exp_snap: 4'b0100};

        // Reset state
        repeat (3) @(negedge clk);
        $display("reset: busy=%b valid=%b sel=%b snap=%b", busy, snap_valid, {s1, s0}, snap);
        check_idle(4'b0000, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(4'b0000, 4'b0000);

        // Table-driven single scans, snap_ready held high throughout
        for (int i = 0; i < 7; i++) begin
            set_channels(vecs[i].val, vecs[i].zmask);
            ex = model_xz(ch_val);
            snap_ready = 1'b1;
            cont  = 1'b0;
            start = 1'b1;
            check_scan(vecs[i].exp_snap, ex, last_snap, last_xz, (i % 2) == 1, 1'b0);
            last_snap = vecs[i].exp_snap;
            last_xz   = ex;
            @(negedge clk);
            check_idle(last_snap, last_xz);
        end

        // Consumer stalls five edges in DONE; start pulses and input changes ignored
        set_channels(4'b1010, 4'b0000);
        snap_ready = 1'b0;
        start = 1'b1;
        check_scan(4'b1010, 4'b0000, last_snap, last_xz, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            start  = ~start;
            ch_val = 4'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(snap_valid), 32'd1);
            chk("stall_snap", 32'({snap, snap_xz}), 32'({4'b1010, 4'b0000}));
            chk("stall_sel", 32'({s1, s0}), 32'd3);
        end
        snap_ready = 1'b1;
        start = 1'b0;
        @(negedge clk);
        last_snap = 4'b1010;
        last_xz   = 4'b0000;
        check_idle(last_snap, last_xz);

        // Continuous mode: back-to-back snapshots, cont dropped mid second scan
        set_channels(4'b1010, 4'b0000);
        cont  = 1'b1;
        start = 1'b1;
        check_scan(4'b1010, 4'b0000, last_snap, last_xz, 1'b0, 1'b0);
        set_channels(4'b0101, 4'b0000);
        check_scan(4'b0101, 4'b0000, 4'b1010, 4'b0000, 1'b1, 1'b1);
        @(negedge clk);
        last_snap = 4'b0101;
        last_xz   = 4'b0000;
        check_idle(last_snap, last_xz);

        // Asynchronous reset in the middle of a scan
        set_channels(4'b0110, 4'b0000);
        start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: busy=%b sel=%b snap=%b valid=%b", busy, {s1, s0}, snap, snap_valid);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'({s1, s0}), 32'd0);
        chk("rst_snap", 32'({snap, snap_xz}), 32'd0);
        chk("rst_valid", 32'(snap_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        last_snap = 4'b0000;
        last_xz   = 4'b0000;
        check_idle(last_snap, last_xz);
        set_channels(4'b1001, 4'b0000);
        start = 1'b1;
        check_scan(4'b1001, 4'b0000, last_snap, last_xz, 1'b0, 1'b0);
        @(negedge clk);
        last_snap = 4'b1001;
        check_idle(last_snap, last_xz);

        // Randomized scans with random consumer latency
        for (int r = 0; r < 20; r++) begin
            int lat;
            logic [3:0] zm;
            zm  = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            set_channels(4'($urandom), zm);
            es  = model_lvl(ch_val);
            ex  = model_xz(ch_val);
            lat = $urandom_range(0, 3);
            snap_ready = (lat == 0);
            cont  = 1'b0;
            start = 1'b1;
            check_scan(es, ex, last_snap, last_xz, 1'b1, 1'b0);
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                chk("rand_stall_valid", 32'(snap_valid), 32'd1);
                chk("rand_stall_snap", 32'({snap, snap_xz}), 32'({es, ex}));
                if (c == lat) snap_ready = 1'b1;
            end
            @(negedge clk);
            last_snap = es;
            last_xz   = ex;
            check_idle(last_snap, last_xz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
